// File: rtl/moving_average_sink_if.sv
// Purpose: bundles the moving_average_sink filter-side inputs, read port and status outputs.
// Latency: n/a (wiring only).
// Backpressure: none here; rd_en/rd_valid and full/overflow carry flow state.
//
// Signals:
//   enable_n  filter enable, active-low (same net that gates moving_average)
//   Z         filter output sample
//   rd_en     read request from the consumer
//   rd_data   registered FIFO head, valid when rd_valid is high
//   rd_valid  one-cycle pulse per accepted read
//   empty/full/count   FIFO occupancy status
//   z_min/z_max        extremes of all captured samples since reset
//   overflow  sticky flag, a capture was dropped because the FIFO was full
//
// Modports: master = host/filter side (drives enable_n, Z, rd_en),
//           slave  = the sink itself.
interface moving_average_sink_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) ();
    logic              enable_n;
    logic [WIDTH-1:0]  Z;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [WIDTH-1:0]  z_min;
    logic [WIDTH-1:0]  z_max;
    logic              overflow;

    modport master (
        output enable_n, Z, rd_en,
        input  rd_data, rd_valid, empty, full, count, z_min, z_max, overflow
    );

    modport slave (
        input  enable_n, Z, rd_en,
        output rd_data, rd_valid, empty, full, count, z_min, z_max, overflow
    );
endinterface

// File: rtl/moving_average_sink.sv
// Purpose: captures moving_average output Z after the filter window has filled, into a FIFO.
// Latency: capture-to-FIFO 1 cycle; rd_en to rd_data/rd_valid 1 cycle.
// Backpressure: none toward the filter; a capture into a full FIFO is dropped and flags overflow.
//
// Ports:
//   Clk    system clock, everything on the rising edge
//   Reset  synchronous, active-high; overrides every other input
//   bus    moving_average_sink_if.slave: enable_n, Z, rd_en in;
//          rd_data, rd_valid, empty, full, count, z_min, z_max, overflow out
//
// The sink follows the filter's enable_n: the first TAPS-1 samples of every run
// are still filling the filter window, so they are discarded. After that every
// sample cycle is a capture. Dropping enable_n back high ends the run; FIFO
// contents and min/max survive, only the warm-up restarts.
module moving_average_sink #(
    parameter int WIDTH      = 8,
    parameter int TAPS       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    moving_average_sink_if.slave bus
);

    // Warm counter only has to reach TAPS-1.
    localparam int WARM_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    // Value of the warm counter on the sample that completes the warm-up
    // (that sample increments it to TAPS-1).
    localparam logic [WARM_W-1:0] WARM_PENULT = WARM_W'((TAPS > 2) ? (TAPS - 2) : 0);
    localparam logic [ADDR_W:0]   FULL_CNT    = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state;
    logic [WARM_W-1:0]   warm;

    logic [WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     cnt;

    logic [WIDTH-1:0]    rd_data_q;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    z_min_q;
    logic [WIDTH-1:0]    z_max_q;
    logic                overflow_q;

    logic                sample;
    logic                capture;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                drop;

    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == FULL_CNT);

    assign sample = ~bus.enable_n;

    // With a one-tap window there is nothing to fill: the very first sample
    // seen from IDLE is already a valid average.
    assign capture = sample && ((state == CAPTURE) || ((state == IDLE) && (TAPS == 1)));

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    // On an empty FIFO the pop is refused, so the push still goes ahead.
    assign pop  = bus.rd_en && !fifo_empty;
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && !push;

    // Run-phase FSM: decides which sample cycles are discards and which are captures.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            warm  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample) begin
                        if (TAPS == 1) begin
                            state <= CAPTURE;
                            warm  <= '0;
                        end else begin
                            // This sample is discard number 1.
                            warm  <= WARM_W'(1);
                            state <= (TAPS == 2) ? CAPTURE : WARMUP;
                        end
                    end
                end
                WARMUP: begin
                    if (!sample) begin
                        state <= IDLE;
                        warm  <= '0;
                    end else begin
                        warm <= warm + WARM_W'(1);
                        if (warm == WARM_PENULT) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (!sample) begin
                        state <= IDLE;
                        warm  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    warm  <= '0;
                end
            endcase
        end
    end

    // FIFO control, read port and capture statistics.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            z_min_q    <= '1;
            z_max_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;

            if (pop) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            case ({push, pop})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase

            // Extremes track every capture, even ones the FIFO had to drop.
            if (capture) begin
                if (bus.Z < z_min_q) begin
                    z_min_q <= bus.Z;
                end
                if (bus.Z > z_max_q) begin
                    z_max_q <= bus.Z;
                end
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: count gates every read of it. When full with a
    // simultaneous push and pop, both pointers are equal and the read above
    // sees the old head before this write lands.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.Z;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.count    = cnt;
    assign bus.z_min    = z_min_q;
    assign bus.z_max    = z_max_q;
    assign bus.overflow = overflow_q;

endmodule
